// File: rtl/sub_share_pkg.sv
// sub_share_pkg: shared types and helpers for the shared `sub` issue controller.
//   state_e   : controller state (IDLE / RUN / DRAIN)
//   id_w()    : requester-id width, max(1, clog2(n))
//   tag_t     : one tag-pipe stage {valid, id}; id is sized for the largest
//               supported requester count and narrowed at the response register
package sub_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned TAG_ID_W = 16;

  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/sub_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a registered priority pointer.
//   clk, rstn : clock, async active-low reset
//   req       : request vector
//   en        : grant enable; 0 forces gnt to zero
//   advance   : a grant was taken this cycle; pointer moves past gnt_id
//   gnt       : one-hot grant (combinational)
//   gnt_id    : index of the granted requester (combinational)
module rr_arbiter
  import sub_share_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] ptr_q;
  int unsigned     idx;
  logic [ID_W-1:0] idx_w;
  logic            found;

  // Search starts at the pointer and wraps; first valid request wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = ID_W'(idx);
      if (en && !found && req[idx_w]) begin
        found      = 1'b1;
        gnt[idx_w] = 1'b1;
        gnt_id     = idx_w;
      end
    end
  end

  // Pointer moves to the requester after the one just served.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (32'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/sub_share_ctrl.sv
// sub_share_ctrl: time-multiplexes one `sub` datapath among NUM_REQ requesters.
//   clk, rstn          : clock, async active-low reset
//   en                 : issue enable; dropping it drains in-flight work
//   idle               : IDLE state with nothing in flight
//   req_valid/ready    : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b       : packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sub_a, sub_b       : registered operands to `sub`
//   sub_z              : result from `sub`, SUB_LAT cycles after sub_a/sub_b
//   rsp_valid/id/z     : registered one-cycle result with requester id
module sub_share_ctrl
  import sub_share_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned SUB_LAT    = 1,
  localparam int unsigned ID_W       = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  output logic                          idle,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0]         sub_a,
  output logic [DATA_WIDTH-1:0]         sub_b,
  input  logic [DATA_WIDTH-1:0]         sub_z,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_z
);

  localparam int unsigned STAGES = SUB_LAT + 1;

  state_e                  state_q, state_d;
  tag_t                    tag_q [STAGES];
  logic                    grant_en_c;
  logic                    issue_c;
  logic [ID_W-1:0]         gnt_id_c;
  logic [DATA_WIDTH-1:0]   sel_a_c, sel_b_c;
  logic                    inflight_c;
  logic                    inflight_next_c;

  assign grant_en_c = (state_q == RUN) && en;
  assign issue_c    = |(req_valid & req_ready);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req_valid),
    .en      (grant_en_c),
    .advance (issue_c),
    .gnt     (req_ready),
    .gnt_id  (gnt_id_c)
  );

  // One-hot operand mux driven by the grant.
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_a_c = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b_c = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Work in the tag pipe now, and work that will be in it next cycle.
  always_comb begin
    inflight_c      = 1'b0;
    inflight_next_c = issue_c;
    for (int unsigned k = 0; k < STAGES; k++) begin
      inflight_c = inflight_c | tag_q[k].valid;
      if (k < SUB_LAT) inflight_next_c = inflight_next_c | tag_q[k].valid;
    end
  end

  // Enable / drain state machine; DRAIN always passes through IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = inflight_c ? DRAIN : IDLE;
      DRAIN:   if (!inflight_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      idle      <= 1'b1;
      sub_a     <= '0;
      sub_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= '0;
      for (int unsigned k = 0; k < STAGES; k++) tag_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idle    <= (state_d == IDLE) && !inflight_next_c;
      if (issue_c) begin
        sub_a <= sel_a_c;
        sub_b <= sel_b_c;
      end
      // Tag pipe tracks each issue to the cycle its sub_z is valid.
      tag_q[0].valid <= issue_c;
      tag_q[0].id    <= issue_c ? TAG_ID_W'(gnt_id_c) : '0;
      for (int unsigned k = 1; k < STAGES; k++) tag_q[k] <= tag_q[k-1];
      rsp_valid <= tag_q[SUB_LAT].valid;
      if (tag_q[SUB_LAT].valid) begin
        rsp_id <= ID_W'(tag_q[SUB_LAT].id);
        rsp_z  <= sub_z;
      end
    end
  end

  // Stored ids must always name a real requester.
  always_comb begin
    assert (tag_q[SUB_LAT].id < TAG_ID_W'(NUM_REQ));
  end

endmodule
